// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Brief    : Instruction fetch stage. Issues one request at a time to the
//             instruction SRAM, holds the fetched word for decode and
//             buffers a branch redirect that arrives before it can be used.
//  Options  : FS_PC_ALIGN_CHK_EN - when defined, a misaligned fetch PC is
//             never sent to the SRAM; a zero instruction word is handed to
//             decode at that PC instead.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   // decode handshake and branch feedback
   input  logic        ds_allowin,
   input  logic [33:0] br_bus,
   output logic        fs_to_ds_valid,
   output logic [63:0] fs_to_ds_bus,
   // instruction SRAM request/response
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   // IDLE : first cycle out of reset
   // REQ  : request for req_pc presented to the SRAM
   // WAIT : request accepted, waiting for the read data
   // FULL : instruction held for decode
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_FULL = 2'd3
   } fs_state_e;

   localparam logic [1:0]  C_SIZE_WORD = 2'd2;
   localparam logic [31:0] C_PC_STEP   = 32'd4;

   fs_state_e   state_q,     state_d;
   logic [31:0] req_pc_q,    req_pc_d;
   logic [31:0] fs_pc_q,     fs_pc_d;
   logic [31:0] fs_inst_q,   fs_inst_d;
   logic        bt_valid_q,  bt_valid_d;
   logic [31:0] bt_target_q, bt_target_d;

   logic        br_stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        br_redirect;
   logic        pc_misaligned;
   logic        advance;
   logic [31:0] nextpc;

   assign br_stall    = br_bus[33];
   assign br_taken    = br_bus[32];
   assign br_target   = br_bus[31:0];
   assign br_redirect = br_taken & ~br_stall;

`ifdef FS_PC_ALIGN_CHK_EN
   assign pc_misaligned = (req_pc_q[1:0] != 2'b00);
`else
   assign pc_misaligned = 1'b0;
`endif

   // A branch buffered earlier wins over one arriving now; otherwise a
   // live taken branch redirects, else fall through to the next word.
   always_comb begin
      nextpc = fs_pc_q + C_PC_STEP;
      if (bt_valid_q) begin
         nextpc = bt_target_q;
      end else if (br_redirect) begin
         nextpc = br_target;
      end
   end

   // Fetch sequencing: next state plus the PC/instruction/branch registers.
   always_comb begin
      state_d     = state_q;
      req_pc_d    = req_pc_q;
      fs_pc_d     = fs_pc_q;
      fs_inst_d   = fs_inst_q;
      bt_valid_d  = bt_valid_q;
      bt_target_d = bt_target_q;
      advance     = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d  = S_REQ;
            req_pc_d = RESET_PC;
         end
         S_REQ: begin
            if (pc_misaligned) begin
               // Unfetchable address: pass a null word straight to decode.
               state_d   = S_FULL;
               fs_pc_d   = req_pc_q;
               fs_inst_d = 32'h0;
            end else if (inst_sram_addr_ok) begin
               state_d = S_WAIT;
               fs_pc_d = req_pc_q;
            end
         end
         S_WAIT: begin
            if (inst_sram_data_ok) begin
               state_d   = S_FULL;
               fs_inst_d = inst_sram_rdata;
            end
         end
         S_FULL: begin
            if (ds_allowin && !br_stall) begin
               advance  = 1'b1;
               state_d  = S_REQ;
               req_pc_d = nextpc;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The buffered target is consumed by the hand-off to decode; on any
      // other cycle a resolved taken branch is remembered for later.
      if (advance) begin
         bt_valid_d = 1'b0;
      end else if (br_redirect) begin
         bt_valid_d  = 1'b1;
         bt_target_d = br_target;
      end
   end

   // State and datapath registers; reset abandons any outstanding request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         req_pc_q    <= RESET_PC;
         fs_pc_q     <= 32'h0;
         fs_inst_q   <= 32'h0;
         bt_valid_q  <= 1'b0;
         bt_target_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         req_pc_q    <= req_pc_d;
         fs_pc_q     <= fs_pc_d;
         fs_inst_q   <= fs_inst_d;
         bt_valid_q  <= bt_valid_d;
         bt_target_q <= bt_target_d;
      end
   end

   // Outputs: decode sees the delay-slot PC from the moment it is requested.
   always_comb begin
      inst_sram_req   = (state_q == S_REQ) && !pc_misaligned;
      inst_sram_addr  = req_pc_q;
      inst_sram_wr    = 1'b0;
      inst_sram_size  = C_SIZE_WORD;
      inst_sram_wdata = 32'h0;
      fs_to_ds_valid  = (state_q == S_FULL) && !br_stall;
      if (state_q == S_REQ) begin
         fs_to_ds_bus = {fs_inst_q, req_pc_q};
      end else begin
         fs_to_ds_bus = {fs_inst_q, fs_pc_q};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Brief    : Randomised bench for if_stage against a transaction-level
//             model of the fetch stream and an SRAM slave model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset;
   logic        ds_allowin;
   logic [33:0] br_bus;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk               (clk),
      .reset             (reset),
      .ds_allowin        (ds_allowin),
      .br_bus            (br_bus),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_wdata   (inst_sram_wdata),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction memory contents as seen by the SRAM slave.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RESET_PC) return 32'h24010001;
      return (a * 32'd2654435761) ^ 32'h13579BDF;
   endfunction

   // Stimulus knobs, percentages.
   int pa_ok, pd_ok, pallow, pbr, pstall;

   // Fetch-stream model.
   logic [31:0] m_pc;        // PC of the instruction being fetched or held
   bit          m_want;      // a request should be on the SRAM port
   bit          m_have;      // an instruction is held for decode
   bit          m_started;   // first edge after reset release has happened
   bit          m_bt_v;      // redirect remembered for the next hand-off
   logic [31:0] m_bt;
   // SRAM slave.
   bit          s_pend;
   logic [31:0] s_addr;
   // Bookkeeping.
   int          cycle;
   int          first_valid;
   logic [63:0] first_bus;
   int          n_deliv;
   int          tot_deliv = 0;

   // One clock cycle: drive inputs, check outputs, advance the model.
   task automatic step();
      bit          stall, taken, accept, deliver;
      logic [31:0] tgt;
      stall = ($urandom_range(99) < pstall);
      taken = ($urandom_range(99) < pbr);
      tgt   = RESET_PC + ($urandom_range(0, 1023) << 2);
      br_bus            = {stall, taken, tgt};
      ds_allowin        = ($urandom_range(99) < pallow);
      inst_sram_addr_ok = ($urandom_range(99) < pa_ok);
      inst_sram_data_ok = s_pend && ($urandom_range(99) < pd_ok);
      inst_sram_rdata   = inst_sram_data_ok ? mem_word(s_addr) : $urandom();
      #4;
      check_eq("req", inst_sram_req, m_want);
      if (m_want) begin
         check_eq("req_addr", inst_sram_addr, m_pc);
         check_eq("req_bus_pc", fs_to_ds_bus[31:0], m_pc);
      end
      if (s_pend) check_eq("wait_bus_pc", fs_to_ds_bus[31:0], m_pc);
      check_eq("valid", fs_to_ds_valid, m_have && !stall);
      if (m_have) check_eq("full_bus", fs_to_ds_bus, {mem_word(m_pc), m_pc});
      if (fs_to_ds_valid && first_valid < 0) begin
         first_valid = cycle;
         first_bus   = fs_to_ds_bus;
      end
      accept  = m_want && inst_sram_addr_ok;
      deliver = m_have && !stall && ds_allowin;
      if (inst_sram_data_ok) begin
         s_pend = 1'b0;
         m_have = 1'b1;
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
         s_pend = 1'b1;
         s_addr = inst_sram_addr;
      end
      if (accept) m_want = 1'b0;
      if (deliver) begin
         m_pc   = m_bt_v ? m_bt : (taken && !stall) ? tgt : m_pc + 32'd4;
         m_bt_v = 1'b0;
         m_have = 1'b0;
         m_want = 1'b1;
         n_deliv++;
         tot_deliv++;
      end else if (taken && !stall) begin
         m_bt_v = 1'b1;
         m_bt   = tgt;
      end
      if (!m_started) begin
         m_started = 1'b1;
         m_want    = 1'b1;
      end
      @(posedge clk);
      #1;
      cycle++;
   endtask

   // Hold reset for n edges, check the reset outputs, then release.
   task automatic do_reset(input int n);
      reset             = 1'b1;
      ds_allowin        = 1'b0;
      br_bus            = '0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = '0;
      s_pend = 1'b0; m_want = 1'b0; m_have = 1'b0; m_started = 1'b0;
      m_bt_v = 1'b0; m_pc = RESET_PC;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      check_eq("rst_req", inst_sram_req, 1'b0);
      check_eq("rst_valid", fs_to_ds_valid, 1'b0);
      check_eq("rst_bus", fs_to_ds_bus, 64'h0);
      reset       = 1'b0;
      cycle       = 0;
      first_valid = -1;
      n_deliv     = 0;
   endtask

   task automatic set_knobs(input int a, input int d, input int al, input int b, input int s);
      pa_ok = a; pd_ok = d; pallow = al; pbr = b; pstall = s;
   endtask

   initial begin
      reset = 1'b1;
      set_knobs(100, 100, 100, 0, 0);
      do_reset(3);
      check_eq("tie_wr", inst_sram_wr, 1'b0);
      check_eq("tie_size", inst_sram_size, 2'd2);
      check_eq("tie_wdata", inst_sram_wdata, 32'h0);

      // Back-to-back single-cycle handshakes: first word, then 1 per 3 cycles.
      repeat (15) step();
      check_eq("first_valid_cycle", first_valid, 3);
      check_eq("first_bus", first_bus, {32'h24010001, RESET_PC});
      check_eq("throughput", n_deliv, 4);

      // Decode stalled by a branch in FULL, then released without a branch.
      for (int i = 0; i < 20 && !m_have; i++) step();
      check_eq("tmo_full1", m_have, 1'b1);
      set_knobs(100, 100, 100, 0, 100);
      repeat (4) step();
      set_knobs(100, 100, 100, 0, 0);
      repeat (6) step();

      // Branch resolved while the delay slot is being requested.
      for (int i = 0; i < 20 && !m_want; i++) step();
      check_eq("tmo_req1", m_want, 1'b1);
      set_knobs(100, 100, 100, 100, 0);
      step();
      set_knobs(100, 100, 100, 0, 0);
      repeat (9) step();

      // Slave slow to accept: address must hold.
      for (int i = 0; i < 20 && !m_want; i++) step();
      set_knobs(0, 100, 100, 0, 0);
      repeat (5) step();

      // Reset while waiting for data, then refetch from RESET_PC.
      set_knobs(100, 0, 100, 0, 0);
      for (int i = 0; i < 20 && !s_pend; i++) step();
      check_eq("tmo_wait", s_pend, 1'b1);
      reset = 1'b1;
      #1;
      check_eq("rst_wait_req", inst_sram_req, 1'b0);
      check_eq("rst_wait_valid", fs_to_ds_valid, 1'b0);
      set_knobs(100, 100, 0, 0, 0);
      do_reset(2);
      repeat (4) step();
      check_eq("refetch_have", m_have, 1'b1);

      // Reset while holding an instruction drops valid at once.
      check_eq("pre_rst_valid", fs_to_ds_valid, 1'b1);
      reset = 1'b1;
      #1;
      check_eq("rst_full_valid", fs_to_ds_valid, 1'b0);
      do_reset(2);

      // Randomised traffic under several mixes.
      set_knobs(60, 60, 60, 15, 20);
      repeat (2000) step();
      set_knobs(30, 80, 90, 40, 10);
      repeat (1500) step();
      set_knobs(100, 100, 100, 30, 50);
      repeat (1500) step();
      check_eq("progress", tot_deliv > 300, 1'b1);

      // Misaligned branch target is requested unchanged.
      do_reset(2);
      set_knobs(100, 100, 0, 0, 0);
      for (int i = 0; i < 20 && !m_have; i++) step();
      check_eq("tmo_full2", m_have, 1'b1);
      ds_allowin        = 1'b1;
      br_bus            = {1'b0, 1'b1, 32'hBFC00102};
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      @(posedge clk);
      #1;
      ds_allowin = 1'b0;
      br_bus     = '0;
      #2;
      check_eq("misalign_req", inst_sram_req, 1'b1);
      check_eq("misalign_addr", inst_sram_addr, 32'hBFC00102);
      check_eq("misalign_bus_pc", fs_to_ds_bus[31:0], 32'hBFC00102);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
